// File: rtl/dp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram_arbiter
// Purpose  : Two-client round-robin arbiter for a simple dual-port RAM with
//            2-cycle read latency; steers read data back via a tag pipeline.
// Revision : 1.0
// ============================================================================
module dp_ram_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          rst,

    input  logic          c0_rd_req,
    input  logic [AW-1:0] c0_rd_addr,
    output logic          c0_rd_gnt,
    output logic          c0_rd_valid,
    output logic [DW-1:0] c0_rd_data,
    input  logic          c0_wr_req,
    input  logic [AW-1:0] c0_wr_addr,
    input  logic [DW-1:0] c0_wr_data,
    output logic          c0_wr_gnt,

    input  logic          c1_rd_req,
    input  logic [AW-1:0] c1_rd_addr,
    output logic          c1_rd_gnt,
    output logic          c1_rd_valid,
    output logic [DW-1:0] c1_rd_data,
    input  logic          c1_wr_req,
    input  logic [AW-1:0] c1_wr_addr,
    input  logic [DW-1:0] c1_wr_data,
    output logic          c1_wr_gnt,

    output logic [AW-1:0] ram_rdaddress,
    output logic [AW-1:0] ram_wraddress,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q
);

    // Winner id: the lone requester, or the client other than the last winner.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        return (req == 2'b11) ? ~last : req[1];
    endfunction

    logic       r_rd_last;
    logic       r_wr_last;
    logic       r_tag0_valid;
    logic       r_tag0_id;
    logic       r_tag1_valid;
    logic       r_tag1_id;

    logic [1:0] w_rd_req;
    logic [1:0] w_wr_req;
    logic       w_rd_any;
    logic       w_wr_any;
    logic       w_rd_win;
    logic       w_wr_win;

    assign w_rd_req = {c1_rd_req, c0_rd_req};
    assign w_wr_req = {c1_wr_req, c0_wr_req};

    // Grants are suppressed while in reset so nothing reaches the RAM.
    assign w_rd_any = (|w_rd_req) & ~rst;
    assign w_wr_any = (|w_wr_req) & ~rst;
    assign w_rd_win = rr_pick(w_rd_req, r_rd_last);
    assign w_wr_win = rr_pick(w_wr_req, r_wr_last);

    assign c0_rd_gnt = w_rd_any & ~w_rd_win;
    assign c1_rd_gnt = w_rd_any &  w_rd_win;
    assign c0_wr_gnt = w_wr_any & ~w_wr_win;
    assign c1_wr_gnt = w_wr_any &  w_wr_win;

    assign ram_rdaddress = w_rd_any ? (w_rd_win ? c1_rd_addr : c0_rd_addr) : '0;
    assign ram_wraddress = w_wr_any ? (w_wr_win ? c1_wr_addr : c0_wr_addr) : '0;
    assign ram_data      = w_wr_any ? (w_wr_win ? c1_wr_data : c0_wr_data) : '0;
    assign ram_wren      = w_wr_any;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_rd_last    <= 1'b1;
            r_wr_last    <= 1'b1;
            r_tag0_valid <= 1'b0;
            r_tag0_id    <= 1'b0;
            r_tag1_valid <= 1'b0;
            r_tag1_id    <= 1'b0;
        end else begin
            if (w_rd_any) begin
                r_rd_last <= w_rd_win;
            end
            if (w_wr_any) begin
                r_wr_last <= w_wr_win;
            end
            r_tag0_valid <= w_rd_any;
            r_tag0_id    <= w_rd_win;
            r_tag1_valid <= r_tag0_valid;
            r_tag1_id    <= r_tag0_id;
        end
    end

    // Tag stage 1 lines up with the RAM's registered output.
    assign c0_rd_valid = r_tag1_valid & ~r_tag1_id;
    assign c1_rd_valid = r_tag1_valid &  r_tag1_id;
    assign c0_rd_data  = ram_q;
    assign c1_rd_data  = ram_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_ram_arbiter
// Purpose  : Directed bench for dp_ram_arbiter with a 2-cycle RAM model and a
//            read-return scoreboard.
// Revision : 1.0
// ============================================================================
module tb_dp_ram_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          rst;
    logic          c0_rd_req, c1_rd_req, c0_wr_req, c1_wr_req;
    logic [AW-1:0] c0_rd_addr, c1_rd_addr, c0_wr_addr, c1_wr_addr;
    logic [DW-1:0] c0_wr_data, c1_wr_data;
    logic          c0_rd_gnt, c1_rd_gnt, c0_wr_gnt, c1_wr_gnt;
    logic          c0_rd_valid, c1_rd_valid;
    logic [DW-1:0] c0_rd_data, c1_rd_data;
    logic [AW-1:0] ram_rdaddress, ram_wraddress;
    logic [DW-1:0] ram_data, ram_q;
    logic          ram_wren;

    dp_ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock(clock), .rst(rst),
        .c0_rd_req(c0_rd_req), .c0_rd_addr(c0_rd_addr), .c0_rd_gnt(c0_rd_gnt),
        .c0_rd_valid(c0_rd_valid), .c0_rd_data(c0_rd_data),
        .c0_wr_req(c0_wr_req), .c0_wr_addr(c0_wr_addr), .c0_wr_data(c0_wr_data),
        .c0_wr_gnt(c0_wr_gnt),
        .c1_rd_req(c1_rd_req), .c1_rd_addr(c1_rd_addr), .c1_rd_gnt(c1_rd_gnt),
        .c1_rd_valid(c1_rd_valid), .c1_rd_data(c1_rd_data),
        .c1_wr_req(c1_wr_req), .c1_wr_addr(c1_wr_addr), .c1_wr_data(c1_wr_data),
        .c1_wr_gnt(c1_wr_gnt),
        .ram_rdaddress(ram_rdaddress), .ram_wraddress(ram_wraddress),
        .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    // RAM: read address and first data register at end of T, second at end of T+1.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_q0, r_q1;
    always @(posedge clock) begin
        if (ram_wren) ram_mem[ram_wraddress] <= ram_data;
        r_q0 <= ram_mem[ram_rdaddress];
        r_q1 <= r_q0;
    end
    assign ram_q = r_q1;

    typedef struct {
        int            due;
        bit            id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    bit            m_rd_last = 1'b1;
    bit            m_wr_last = 1'b1;
    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    bit            valid_known = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Checks one cycle against the model, updates the model, advances a clock.
    task automatic tick();
        bit            rd_any, wr_any, rd_win, wr_win, e_v0, e_v1;
        logic [AW-1:0] e_rda, e_wra;
        logic [DW-1:0] e_wd;
        exp_t          e;
        #4;
        rd_any = !rst && (c0_rd_req || c1_rd_req);
        wr_any = !rst && (c0_wr_req || c1_wr_req);
        if (c0_rd_req && c1_rd_req) rd_win = !m_rd_last; else rd_win = c1_rd_req;
        if (c0_wr_req && c1_wr_req) wr_win = !m_wr_last; else wr_win = c1_wr_req;
        e_rda = !rd_any ? '0 : (rd_win ? c1_rd_addr : c0_rd_addr);
        e_wra = !wr_any ? '0 : (wr_win ? c1_wr_addr : c0_wr_addr);
        e_wd  = !wr_any ? '0 : (wr_win ? c1_wr_data : c0_wr_data);

        chk("c0_rd_gnt", c0_rd_gnt, rd_any && !rd_win);
        chk("c1_rd_gnt", c1_rd_gnt, rd_any &&  rd_win);
        chk("c0_wr_gnt", c0_wr_gnt, wr_any && !wr_win);
        chk("c1_wr_gnt", c1_wr_gnt, wr_any &&  wr_win);
        chk("ram_rdaddress", ram_rdaddress, e_rda);
        chk("ram_wraddress", ram_wraddress, e_wra);
        chk("ram_data", ram_data, e_wd);
        chk("ram_wren", ram_wren, wr_any);

        if (valid_known) begin
            e_v0 = 1'b0;
            e_v1 = 1'b0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                e_v0 = !e.id;
                e_v1 = e.id;
                if (e.id) chk("c1_rd_data", c1_rd_data, e.data);
                else      chk("c0_rd_data", c0_rd_data, e.data);
            end
            chk("c0_rd_valid", c0_rd_valid, e_v0);
            chk("c1_rd_valid", c1_rd_valid, e_v1);
        end

        if (rst) begin
            sb.delete();
            m_rd_last = 1'b1;
            m_wr_last = 1'b1;
        end else begin
            if (rd_any) begin
                e.due  = cyc + 2;
                e.id   = rd_win;
                e.data = shadow[e_rda];
                sb.push_back(e);
                m_rd_last = rd_win;
            end
            if (wr_any) begin
                shadow[e_wra] = e_wd;
                m_wr_last = wr_win;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wr(input bit id, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id) begin c1_wr_req = 1; c1_wr_addr = a; c1_wr_data = d; end
        else    begin c0_wr_req = 1; c0_wr_addr = a; c0_wr_data = d; end
        tick();
        c0_wr_req = 0;
        c1_wr_req = 0;
    endtask

    task automatic rd(input bit id, input logic [AW-1:0] a);
        if (id) begin c1_rd_req = 1; c1_rd_addr = a; end
        else    begin c0_rd_req = 1; c0_rd_addr = a; end
        tick();
        c0_rd_req = 0;
        c1_rd_req = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst = 1;
        c0_rd_req = 0; c1_rd_req = 0; c0_wr_req = 0; c1_wr_req = 0;
        c0_rd_addr = '0; c1_rd_addr = '0; c0_wr_addr = '0; c1_wr_addr = '0;
        c0_wr_data = '0; c1_wr_data = '0;
        @(posedge clock);
        #1;
        tick();
        valid_known = 1'b1;
        // Requests during reset must not be granted.
        c0_rd_req = 1; c1_wr_req = 1;
        tick();
        c0_rd_req = 0; c1_wr_req = 0;
        rst = 0;
        idle(1);

        for (int i = 0; i < 8; i++) wr(0, AW'(i), 32'h100 + i);
        wr(0, 16'd1, 32'h11);
        wr(0, 16'd2, 32'h22);
        wr(0, 16'd3, 32'h1);
        wr(1, 16'd5, 32'hA5A5_A5A5);

        // Read contention held for 4 cycles: alternating c0, c1.
        c0_rd_req = 1; c0_rd_addr = 16'd1;
        c1_rd_req = 1; c1_rd_addr = 16'd2;
        idle(4);
        c0_rd_req = 0; c1_rd_req = 0;
        idle(2);

        rd(0, 16'd5);
        idle(3);

        // Write contention: c0 first, c1 the next cycle.
        c0_wr_req = 1; c0_wr_addr = 16'd7; c0_wr_data = 32'h7;
        c1_wr_req = 1; c1_wr_addr = 16'd8; c1_wr_data = 32'h8;
        tick();
        c0_wr_req = 0;
        tick();
        c1_wr_req = 0;
        rd(0, 16'd7);
        rd(1, 16'd8);
        idle(3);

        // Same-address read and write in one cycle returns the old value.
        c1_wr_req = 1; c1_wr_addr = 16'd3; c1_wr_data = 32'h2;
        c0_rd_req = 1; c0_rd_addr = 16'd3;
        tick();
        c1_wr_req = 0; c0_rd_req = 0;
        rd(0, 16'd3);
        idle(3);

        // Reset while a read is in flight.
        c0_rd_req = 1; c0_rd_addr = 16'd5;
        tick();
        rst = 1;
        tick();
        rst = 0;
        c0_rd_req = 0;
        idle(2);
        c0_rd_req = 1; c0_rd_addr = 16'd1;
        c1_rd_req = 1; c1_rd_addr = 16'd2;
        tick();
        c0_rd_req = 0;
        tick();
        c1_rd_req = 0;
        idle(3);

        // Back-to-back reads from a single client.
        c1_rd_req = 1;
        for (int i = 0; i < 8; i++) begin
            c1_rd_addr = AW'(i);
            tick();
        end
        c1_rd_req = 0;
        idle(4);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
